// File: rtl/dire_straits_core.sv
// -----------------------------------------------------------------------------
// dire_straits_core
//
// Registered update stage between the A/B/AND producers and the enable /
// steering logic. Each accepted input produces, one cycle later:
//   A_e = (A_out + B_out) mod 2^WIDTH
//   B_e = AND_out, inverted when that sum carries out of WIDTH bits
//   C_e = ~AND_out
// out_valid marks the cycle after each accepted input. When in_valid is low
// the result registers hold and out_valid drops.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset (clears all outputs)
//   in_valid   qualifies A_out / B_out / AND_out for capture
//   A_out      current A value (unsigned)
//   B_out      increment for A (all-ones behaves as -1 through the wrap)
//   AND_out    AND vector to be steered
//   A_e        registered sum
//   B_e        registered, carry-steered AND vector
//   C_e        registered complement of AND vector
//   out_valid  result qualifier, one cycle after acceptance
//   carry_e    registered carry of the accepted input (only when the macro
//              DIRE_STRAITS_CARRY_OUT_EN is defined)
//
// Optional feature macro: DIRE_STRAITS_CARRY_OUT_EN
// -----------------------------------------------------------------------------
module dire_straits_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A_out,
    input  logic [WIDTH-1:0] B_out,
    input  logic [WIDTH-1:0] AND_out,
    output logic [WIDTH-1:0] A_e,
    output logic [WIDTH-1:0] B_e,
    output logic [WIDTH-1:0] C_e,
`ifdef DIRE_STRAITS_CARRY_OUT_EN
    output logic             carry_e,
`endif
    output logic             out_valid
);

    // Widened add so the carry is available as the top bit.
    function automatic logic [WIDTH:0] wide_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        wide_add = {1'b0, a} + {1'b0, b};
    endfunction

    logic [WIDTH:0]   sum_s;
    logic             carry_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] c_next_s;

    logic [WIDTH-1:0] a_e_r;
    logic [WIDTH-1:0] b_e_r;
    logic [WIDTH-1:0] c_e_r;
    logic             out_valid_r;
`ifdef DIRE_STRAITS_CARRY_OUT_EN
    logic             carry_e_r;
`endif

    // Sum, carry and steered AND vector for the current inputs.
    always_comb begin
        sum_s    = wide_add(A_out, B_out);
        carry_s  = sum_s[WIDTH];
        c_next_s = ~AND_out;
        if (carry_s) begin
            b_next_s = ~AND_out;
        end else begin
            b_next_s = AND_out;
        end
    end

    // Result registers: capture on in_valid, otherwise hold (inputs with
    // in_valid low never reach the registers, so X there cannot leak out).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_e_r <= {WIDTH{1'b0}};
            b_e_r <= {WIDTH{1'b0}};
            c_e_r <= {WIDTH{1'b0}};
        end else if (in_valid) begin
            a_e_r <= sum_s[WIDTH-1:0];
            b_e_r <= b_next_s;
            c_e_r <= c_next_s;
        end else begin
            a_e_r <= a_e_r;
            b_e_r <= b_e_r;
            c_e_r <= c_e_r;
        end
    end

    // Valid qualifier: a one-cycle echo of in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
        end
    end

`ifdef DIRE_STRAITS_CARRY_OUT_EN
    // Carry register, loaded alongside A_e.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_e_r <= 1'b0;
        end else if (in_valid) begin
            carry_e_r <= carry_s;
        end else begin
            carry_e_r <= carry_e_r;
        end
    end

    assign carry_e = carry_e_r;
`endif

    assign A_e       = a_e_r;
    assign B_e       = b_e_r;
    assign C_e       = c_e_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_dire_straits_core.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dire_straits_core (WIDTH = 4). Inputs are driven
// on the falling edge, outputs are checked on the following falling edge
// against a reference model that works on plain integers.
// -----------------------------------------------------------------------------
module tb_dire_straits_core;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [W-1:0] and_out;
    logic [W-1:0] a_e;
    logic [W-1:0] b_e;
    logic [W-1:0] c_e;
    logic         out_valid;
`ifdef DIRE_STRAITS_CARRY_OUT_EN
    logic         carry_e;
`endif

    int checks;
    int errors;

    // reference model state
    int m_a;
    int m_b;
    int m_c;
    int m_v;
    int m_carry;

    dire_straits_core #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A_out    (a_out),
        .B_out    (b_out),
        .AND_out  (and_out),
        .A_e      (a_e),
        .B_e      (b_e),
        .C_e      (c_e),
`ifdef DIRE_STRAITS_CARRY_OUT_EN
        .carry_e  (carry_e),
`endif
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), m_v);
        check({tag, ".A_e"}, int'(a_e), m_a);
        check({tag, ".B_e"}, int'(b_e), m_b);
        check({tag, ".C_e"}, int'(c_e), m_c);
`ifdef DIRE_STRAITS_CARRY_OUT_EN
        check({tag, ".carry_e"}, int'(carry_e), m_carry);
`endif
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_c = 0; m_v = 0; m_carry = 0;
    endtask

    // Called at a falling edge: drive, advance one cycle, check.
    task automatic step(input string tag, input int v, input int a, input int b, input int andv);
        int s;
        in_valid = v[0];
        a_out    = W'(a);
        b_out    = W'(b);
        and_out  = W'(andv);
        if (v != 0) begin
            s       = a + b;
            m_carry = (s > MASK) ? 1 : 0;
            m_a     = s % (MASK + 1);
            m_c     = MASK - andv;
            m_b     = m_carry ? (MASK - andv) : andv;
            m_v     = 1;
        end else begin
            m_v = 0;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_out    = '0;
        b_out    = '0;
        and_out  = '0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        check_all("reset_init");
        rst_n = 1'b1;
        @(negedge clk);

        // load A=5,B=15 then assert reset between edges
        step("load_5_15", 1, 5, 15, 9);
        check("load_5_15.nonzero", int'(a_e != '0), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        // inputs must be ignored while reset is held
        in_valid = 1'b1; a_out = 4'd3; b_out = 4'd3; and_out = 4'd5;
        @(negedge clk);
        check_all("reset_hold1");
        @(negedge clk);
        check_all("reset_hold2");
        rst_n = 1'b1;
        step("post_reset_idle", 0, 0, 0, 0);

        // decrement / carry cases (B = 1111)
        step("dec_a0",  1, 4'b0000, 4'b1111, 4'b1010);
        check("dec_a0.const_A", int'(a_e), 15);
        check("dec_a0.const_B", int'(b_e), 10);
        step("dec_a1",  1, 4'b0001, 4'b1111, 4'b1010);
        check("dec_a1.const_B", int'(b_e), 5);
        step("dec_af",  1, 4'b1111, 4'b1111, 4'b1100);
        step("dec_a9",  1, 4'b1001, 4'b1111, 4'b0001);
        check("dec_a9.const_B", int'(b_e), 14);
        // increment / hold cases
        step("inc_4",   1, 4'b0100, 4'b0001, 4'b1010);
        step("inc_7",   1, 4'b0111, 4'b0001, 4'b0000);
        step("hold_f",  1, 4'b1111, 4'b0000, 4'b1110);
        check("hold_f.const_A", int'(a_e), 15);
        // general wrap
        step("wrap_a7", 1, 4'b1010, 4'b0111, 4'b0000);
        check("wrap_a7.const_B", int'(b_e), 15);
        step("wrap_6f", 1, 4'b0110, 4'b1111, 4'b1111);

        // back-to-back then idle: outputs hold, X inputs ignored
        step("b2b_0", 1, 3, 4, 6);
        step("b2b_1", 1, 12, 9, 3);
        step("b2b_2", 1, 8, 8, 13);
        in_valid = 1'b0;
        a_out = 'x; b_out = 'x; and_out = 'x;
        m_v = 0;
        @(negedge clk);
        check_all("idle_0");
        @(negedge clk);
        check_all("idle_1");

`ifdef DIRE_STRAITS_CARRY_OUT_EN
        step("carry_01", 1, 4'b0001, 4'b1111, 0);
        check("carry_01.const", int'(carry_e), 1);
        step("carry_00", 1, 4'b0000, 4'b1111, 0);
        check("carry_00.const", int'(carry_e), 0);
`endif

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            step("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, MASK)),
                 int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
        end

        // final reset
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
